// File: rtl/cpu_memory_responder_if.sv
// CPU memory-pin bundle between the CPU (master) and the memory responder (slave).
// The bidirectional data bus stays a plain inout port on the responder.
interface cpu_memory_responder_if;
    logic        memory_read;
    logic        memory_write;
    logic [15:0] i_addr;
    logic [15:0] i_bus;
    logic [15:0] d_addr;
    logic [7:0]  io_led;

    modport master (
        output memory_read, memory_write, i_addr, d_addr,
        input  i_bus, io_led
    );

    modport slave (
        input  memory_read, memory_write, i_addr, d_addr,
        output i_bus, io_led
    );
endinterface

// File: rtl/cpu_memory_responder.sv
// Shared instruction/data RAM plus an I/O page (LED, cycle counter, status) at 0xFF00-0xFFFF.
// Define BOUNDS_CHECK_EN to trap RAM accesses beyond 2**ADDR_BITS words instead of aliasing.
module cpu_memory_responder #(
    parameter int          ADDR_BITS = 10,
    parameter logic [7:0]  LED_RESET = 8'h00
) (
    input  logic                   clk,
    input  logic                   reset,
    cpu_memory_responder_if.slave  bus,
    inout  wire  [15:0]            d_bus
);
    localparam int DEPTH = 1 << ADDR_BITS;

    logic [15:0] ram [DEPTH];

    logic [15:0] i_bus_reg;
    logic [15:0] rd_data_reg, rd_next;
    logic        rd_valid_reg;
    logic [7:0]  led_reg;
    logic [15:0] cnt_reg, cnt_next;
    logic        bus_drive;

    logic [ADDR_BITS-1:0] d_idx, i_idx;
    logic d_io, i_io, d_oob, i_oob, rd_en, err_bit;

    assign d_idx = bus.d_addr[ADDR_BITS-1:0];
    assign i_idx = bus.i_addr[ADDR_BITS-1:0];
    assign d_io  = (bus.d_addr[15:8] == 8'hFF);
    assign i_io  = (bus.i_addr[15:8] == 8'hFF);
    // A simultaneous write suppresses the read so the bus is never contended.
    assign rd_en = bus.memory_read & ~bus.memory_write;

`ifdef BOUNDS_CHECK_EN
    logic [15:0] hi_mask;
    logic        d_hi, i_hi, err_reg, err_next, err_clr;

    for (genvar gi = 0; gi < 16; gi++) begin : g_hi_mask
        assign hi_mask[gi] = (gi >= ADDR_BITS);
    end

    assign d_hi    = |(bus.d_addr & hi_mask);
    assign i_hi    = |(bus.i_addr & hi_mask);
    assign d_oob   = ~d_io & d_hi;
    assign i_oob   = ~i_io & i_hi;
    assign err_clr = bus.memory_write & d_io & (bus.d_addr[7:0] == 8'h02) & d_bus[0];
    // A fresh error in the clearing cycle takes precedence over the clear.
    assign err_next = (err_reg & ~err_clr)
                    | (d_oob & (bus.memory_read | bus.memory_write))
                    | i_oob;
    assign err_bit  = err_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= err_next;
        end
    end
`else
    assign d_oob   = 1'b0;
    assign i_oob   = 1'b0;
    assign err_bit = 1'b0;
`endif

    always_comb begin
        rd_next = 16'h0000;
        if (d_io) begin
            case (bus.d_addr[7:0])
                8'h00:   rd_next = {8'h00, led_reg};
                8'h01:   rd_next = cnt_reg;
                8'h02:   rd_next = {15'h0000, err_bit};
                default: rd_next = 16'h0000;
            endcase
        end else if (d_oob) begin
            rd_next = 16'hDEAD;
        end else begin
            rd_next = ram[d_idx];
        end
    end

    assign cnt_next = (bus.memory_write && d_io && bus.d_addr[7:0] == 8'h01) ?
                      16'h0000 : cnt_reg + 16'h0001;

    always_ff @(posedge clk) begin
        if (!reset && bus.memory_write && !d_io && !d_oob) begin
            ram[d_idx] <= d_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i_bus_reg    <= 16'h0000;
            rd_data_reg  <= 16'h0000;
            rd_valid_reg <= 1'b0;
            led_reg      <= LED_RESET;
            cnt_reg      <= 16'h0000;
        end else begin
            // Nonblocking read of ram gives read-first behaviour against a same-edge write.
            i_bus_reg    <= (i_io || i_oob) ? 16'h0000 : ram[i_idx];
            rd_valid_reg <= rd_en;
            if (rd_en) begin
                rd_data_reg <= rd_next;
            end
            if (bus.memory_write && d_io && bus.d_addr[7:0] == 8'h00) begin
                led_reg <= d_bus[7:0];
            end
            cnt_reg <= cnt_next;
        end
    end

    assign bus_drive  = rd_valid_reg & bus.memory_read & ~bus.memory_write;
    assign d_bus      = bus_drive ? rd_data_reg : 16'hzzzz;
    assign bus.i_bus  = i_bus_reg;
    assign bus.io_led = led_reg;
endmodule

// File: tb/tb_cpu_memory_responder.sv
// Scoreboard bench: read tasks queue expected words, a negedge monitor checks every driven d_bus cycle.
module tb_cpu_memory_responder;
    localparam int         ADDR_BITS = 10;
    localparam logic [7:0] LED_RESET = 8'h3C;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu_memory_responder_if bus();
    wire  [15:0] d_bus;
    logic [15:0] tb_dout;
    logic        tb_oe;
    assign d_bus = tb_oe ? tb_dout : 16'hzzzz;

    cpu_memory_responder #(
        .ADDR_BITS (ADDR_BITS),
        .LED_RESET (LED_RESET)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .d_bus (d_bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: every cycle the block drives d_bus must match the oldest queued read.
    initial begin
        forever begin
            @(negedge clk);
            if (dut.bus_drive) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_drive: d_bus driven with %h, required high-Z", d_bus);
                end else begin
                    check("read_data", d_bus, exp_q.pop_front());
                end
            end
        end
    end

    task automatic do_write(input logic [15:0] a, input logic [15:0] dat);
        @(posedge clk); #1;
        bus.d_addr = a; tb_dout = dat; tb_oe = 1'b1; bus.memory_write = 1'b1;
        @(posedge clk); #1;
        bus.memory_write = 1'b0; tb_oe = 1'b0;
        $display("write [%h] <= %h", a, dat);
    endtask

    task automatic do_read(input logic [15:0] a, input logic [15:0] e);
        @(posedge clk); #1;
        bus.d_addr = a; bus.memory_read = 1'b1; exp_q.push_back(e);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.memory_read = 1'b0;
    endtask

    task automatic do_read2(input logic [15:0] a0, input logic [15:0] e0,
                            input logic [15:0] a1, input logic [15:0] e1);
        @(posedge clk); #1;
        bus.d_addr = a0; bus.memory_read = 1'b1; exp_q.push_back(e0);
        @(posedge clk); #1;
        bus.d_addr = a1; exp_q.push_back(e1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.memory_read = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.memory_read = 1'b0; bus.memory_write = 1'b0;
        bus.i_addr = 16'h0000; bus.d_addr = 16'h0000;
        tb_oe = 1'b0; tb_dout = 16'h0000;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_i_bus", bus.i_bus, 16'h0000);
        check("reset_led", {8'h00, bus.io_led}, {8'h00, LED_RESET});
        check("reset_drive", 16'(dut.bus_drive), 16'h0000);
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic write then read.
        do_write(16'h0005, 16'h1234);
        do_read(16'h0005, 16'h1234);

        // Same-edge fetch and write: old word first, new word next cycle.
        bus.i_addr = 16'h0010;
        do_write(16'h0010, 16'h1111);
        @(posedge clk); #1;
        bus.d_addr = 16'h0010; tb_dout = 16'hABCD; tb_oe = 1'b1; bus.memory_write = 1'b1;
        @(negedge clk);
        check("fetch_before", bus.i_bus, 16'h1111);
        @(posedge clk); #1;
        bus.memory_write = 1'b0; tb_oe = 1'b0;
        @(negedge clk);
        check("fetch_read_first", bus.i_bus, 16'h1111);
        @(posedge clk);
        @(negedge clk);
        check("fetch_new", bus.i_bus, 16'hABCD);

        // Fetch from the I/O page returns zero rather than aliasing RAM[0x300].
        do_write(16'h0300, 16'h7777);
        bus.i_addr = 16'h0300;
        @(posedge clk);
        @(negedge clk);
        check("fetch_ram_300", bus.i_bus, 16'h7777);
        bus.i_addr = 16'hFF00;
        @(posedge clk);
        @(negedge clk);
        check("fetch_io_page", bus.i_bus, 16'h0000);

        // LED register.
        do_write(16'hFF00, 16'h00A5);
        @(negedge clk);
        check("led_after_write", {8'h00, bus.io_led}, 16'h00A5);
        do_read(16'hFF00, 16'h00A5);

        // Unmapped I/O and status.
        do_write(16'hFF05, 16'h1234);
        do_read(16'hFF05, 16'h0000);
        do_read(16'hFF02, 16'h0000);

        // Read and write together: write lands, block never drives.
        do_write(16'h0020, 16'h1357);
        @(posedge clk); #1;
        bus.d_addr = 16'h0020; tb_dout = 16'h5555; tb_oe = 1'b1;
        bus.memory_read = 1'b1; bus.memory_write = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.memory_read = 1'b0; bus.memory_write = 1'b0; tb_oe = 1'b0;
        do_read(16'h0020, 16'h5555);

        // Address change during a held read is tracked one cycle later.
        do_write(16'h0030, 16'h2222);
        do_write(16'h0031, 16'h3333);
        do_read2(16'h0030, 16'h2222, 16'h0031, 16'h3333);

        // Out-of-range RAM access.
        do_write(16'h0000, 16'hBEEF);
        do_write(16'h0400, 16'h9999);
`ifdef BOUNDS_CHECK_EN
        do_read(16'h0000, 16'hBEEF);
        do_read(16'hFF02, 16'h0001);
        do_read(16'h0400, 16'hDEAD);
        do_write(16'hFF02, 16'h0001);
        do_read(16'hFF02, 16'h0000);
`else
        do_read(16'h0000, 16'h9999);
        do_read(16'hFF02, 16'h0000);
        do_write(16'hFF02, 16'h0001);
        do_read(16'hFF02, 16'h0000);
`endif

        // Counter: clear, 10 edges later the read returns 10.
        do_write(16'hFF01, 16'h0000);
        repeat (9) @(posedge clk);
        do_read(16'hFF01, 16'h000A);

        // Reset in the middle of a read, then a write sampled during reset.
        bus.i_addr = 16'h0010;
        @(posedge clk); #1;
        bus.d_addr = 16'h0005; bus.memory_read = 1'b1; exp_q.push_back(16'h1234);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_mid_read_drive", 16'(dut.bus_drive), 16'h0000);
        check("reset_mid_i_bus", bus.i_bus, 16'h0000);
        check("reset_mid_led", {8'h00, bus.io_led}, {8'h00, LED_RESET});
        bus.memory_read = 1'b0;
        bus.memory_write = 1'b1; tb_oe = 1'b1; tb_dout = 16'h0BAD;
        @(posedge clk); #1;
        reset = 1'b0; bus.memory_write = 1'b0; tb_oe = 1'b0;
        do_read(16'hFF01, 16'h0001);
        do_read(16'h0005, 16'h1234);

        // Counter wrap: FFFF is captured, the following edge captures 0000.
        do_write(16'hFF01, 16'h0000);
        repeat (65534) @(posedge clk);
        do_read2(16'hFF01, 16'hFFFF, 16'hFF01, 16'h0000);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("pending_reads", 16'(exp_q.size()), 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_memory_responder.md
Name: cpu_memory_responder

Overview:
Memory-side responder for the CPU memory interface: serves instruction fetches on i_addr/i_bus and data reads/writes on d_addr/d_bus. Contains a single word-addressed RAM shared by both ports, plus a small memory-mapped I/O page at 0xFF00-0xFFFF. The I/O page holds an LED register, a free-running cycle counter and a status word. Sits at the CPU top level, opposite the CPU's memory pins.

Parameters:
ADDR_BITS, 10, RAM depth is 2**ADDR_BITS 16-bit words; RAM is indexed by address bits [ADDR_BITS-1:0]
LED_RESET, 8'h00, value loaded into the LED register on reset

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
memory_read  input  1  CPU data-read request, held by CPU for the whole access
memory_write  input  1  CPU data-write request; write data valid on d_bus in the same cycle
i_addr  input  16  instruction fetch address
i_bus  output  16  registered instruction word
d_addr  input  16  data address
d_bus  inout  16  data bus; driven by this block only during read data phase, else high-Z
io_led  output  8  LED register contents

Behaviour:
- Reset (reset=1 at edge): i_bus=0x0000, rd_valid=0 (d_bus high-Z), LED register=LED_RESET, cycle counter=0, status=0. RAM contents are not cleared.
- Reset mid-access: any pending read is dropped and d_bus is released on the next edge; a write sampled in the reset cycle is discarded.
- Instruction port: every cycle, i_bus <= RAM[i_addr[ADDR_BITS-1:0]]; latency 1 cycle; no handshake.
- Fetch from 0xFF00-0xFFFF returns 0x0000.
- Address decode: d_addr[15:8]==8'hFF selects the I/O page; otherwise the access goes to RAM.
- Write: memory_write=1 at an edge stores d_bus to the decoded target in that edge.
- Read: memory_read=1 and memory_write=0 at an edge captures the decoded data into rd_data and sets rd_valid=1.
- d_bus is driven with rd_data while rd_valid=1 and memory_read=1; otherwise high-Z. Read latency is 1 cycle.
- rd_valid clears on the first edge where memory_read=0. While memory_read stays high, rd_data re-samples each cycle, so a d_addr change is tracked with 1-cycle lag.
- memory_read and memory_write both high: the write is performed, no read is captured, rd_valid=0, d_bus is high-Z (bus-contention guard).
- Same-edge fetch and write to one RAM word: i_bus returns the old contents (read-first). The new value is visible on the next fetch.
- I/O map:
  - 0xFF00: LED register. R/W, bits [7:0]; reads return {8'h00, led}; writes take d_bus[7:0].
  - 0xFF01: cycle counter. Read-only value; increments every non-reset cycle and wraps 0xFFFF->0x0000. Any write clears it to 0; in that cycle the write wins over the increment.
  - 0xFF02: status. Bit0 is the bounds-error flag (see Optional Feature); other bits read 0.
  - Other 0xFFxx: reads return 0x0000; writes are ignored.
- Counter read coherence: a read of 0xFF01 returns the counter value before the capturing edge's increment.

Optional Feature:
BOUNDS_CHECK_EN
- Defined:
  - A RAM-region data or fetch address with any bit in [15:ADDR_BITS] set is out of range (only when ADDR_BITS<16).
  - Out-of-range data writes are dropped.
  - Out-of-range data reads return 0xDEAD.
  - Out-of-range fetches return 0x0000.
  - Any out-of-range access sets status bit0 (sticky). It is cleared by writing 1 to 0xFF02 bit0 or by reset; a new error in the same cycle as the clear wins.
- Undefined: upper address bits are ignored (RAM aliases), status bit0 reads 0, and writes to 0xFF02 are ignored.

Test Plan:
- Reset, then write 0x1234 to 0x0005, then hold memory_read with d_addr=0x0005 -> d_bus=0x1234 one cycle after the read edge; high-Z once memory_read drops.
- Write 0xABCD to 0x0010 while i_addr=0x0010 on the same edge -> i_bus shows old word, then 0xABCD on the next cycle.
- Write 0x00A5 to 0xFF00 -> io_led=8'hA5 after the edge; read 0xFF00 -> 0x00A5; reset -> io_led=LED_RESET.
- Clear counter by writing 0xFF01, idle 10 cycles, read 0xFF01 -> 0x000A (exact by counting edges); preload by running past 0xFFFF -> wraps to 0x0000.
- Assert memory_read and memory_write together at 0x0020 with d_bus=0x5555 -> d_bus never driven by the block; a subsequent read returns 0x5555.
- BOUNDS_CHECK_EN, ADDR_BITS=10: write to 0x0400 -> RAM[0] unchanged; read 0x0400 -> 0xDEAD; 0xFF02 reads 0x0001; write 0x0001 to 0xFF02 -> 0x0000.
